// File: rtl/board_engine_pkg.sv
// Shared types and constants for the 4x4 tile board engine.
// Cells are numbered row*4+col, row 0 at the top and col 0 at the left.
package board_engine_pkg;

    localparam int EXP_W     = 4;
    localparam int GRID_DIM  = 4;
    localparam int NUM_CELLS = GRID_DIM * GRID_DIM;

    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        EVAL = 2'd2
    } state_t;

    typedef logic [EXP_W-1:0] exp_t;

    function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Cell visited at position j of line k, counting from the wall the tiles slide toward.
    function automatic logic [3:0] line_cell(input logic [3:0] dir, input logic [1:0] k,
                                             input logic [1:0] j);
        logic [3:0] idx;
        case (dir)
            DIR_LEFT:  idx = cell_idx(k, j);
            DIR_RIGHT: idx = cell_idx(k, 2'd3 - j);
            DIR_UP:    idx = cell_idx(j, k);
            default:   idx = cell_idx(2'd3 - j, k);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/board_engine_line.sv
// Combinational slide/merge of one 4-cell line toward index 0.
// Each tile merges at most once; tiles at MAX_EXP never merge.
module line_merge
    import board_engine_pkg::*;
#(
    parameter int MAX_EXP = 15
) (
    input  logic [3:0][EXP_W-1:0] line_in,
    output logic [3:0][EXP_W-1:0] line_out,
    output logic                  line_changed,
    output logic [31:0]           line_score
);

    localparam exp_t MAX_E = exp_t'(MAX_EXP);

    exp_t                  comp [5];
    logic [3:0][EXP_W-1:0] res;
    logic [2:0]            n;
    logic [2:0]            o;
    logic                  skip;

    always_comb begin
        for (int i = 0; i < 5; i++) comp[i] = '0;
        res        = '0;
        n          = '0;
        o          = '0;
        skip       = 1'b0;
        line_score = '0;

        for (int i = 0; i < 4; i++) begin
            if (line_in[i] != '0) begin
                comp[n] = line_in[i];
                n       = n + 3'd1;
            end
        end

        // comp[4] is always empty, so the pair test at i = 3 can never merge.
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[i] != '0) begin
                if (comp[i] == comp[i+1] && comp[i] < MAX_E) begin
                    res[o[1:0]] = comp[i] + exp_t'(1);
                    line_score  = line_score + (32'd1 << (comp[i] + exp_t'(1)));
                    skip        = 1'b1;
                end else begin
                    res[o[1:0]] = comp[i];
                end
                o = o + 3'd1;
            end
        end
    end

    assign line_out     = res;
    assign line_changed = (res != line_in);

endmodule

// File: rtl/board_engine.sv
// Board engine: owns the 4x4 exponent grid, runs one slide/merge line per
// cycle, accepts spawn presets and reports completion, score and movability.
module board_engine
    import board_engine_pkg::*;
#(
    parameter int MAX_EXP = 15,
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         direction,
    input  logic               preset_ext,
    input  logic [3:0]         preset_location,
    input  logic [3:0]         preset_value,
    output logic [63:0]        total_current_state,
    output logic [3:0]         board_done,
    output logic               movable,
    output logic               changed,
    output logic [SCORE_W-1:0] score_delta,
    output logic               busy
);

    localparam exp_t               MAX_E     = exp_t'(MAX_EXP);
    localparam int                 SUM_W     = ((SCORE_W > 32) ? SCORE_W : 32) + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t state, state_nxt;

    exp_t                  grid [NUM_CELLS];
    logic [3:0]            dir_q;
    logic [1:0]            line_cnt;
    logic                  armed;
    logic                  preset_pend;

    logic                  accept_move;
    logic                  write_preset;
    logic                  do_line;
    logic                  do_eval;

    logic [3:0][3:0]       line_idx;
    logic [3:0][EXP_W-1:0] line_in;
    logic [3:0][EXP_W-1:0] line_out;
    logic                  line_changed;
    logic [31:0]           line_score;
    logic [SUM_W-1:0]      score_sum;
    logic [SCORE_W-1:0]    score_sat;
    logic                  movable_scan;

    function automatic logic can_merge(input exp_t a, input exp_t b);
        return (a != '0) && (a == b) && (a < MAX_E);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept_move  = 1'b0;
        write_preset = 1'b0;
        do_line      = 1'b0;
        do_eval      = 1'b0;
        case (state)
            IDLE: begin
                // A preset wins the cycle; a held direction is picked up afterwards.
                if (preset_ext) begin
                    write_preset = (grid[preset_location] == '0);
                end else if (armed && $onehot(direction)) begin
                    accept_move = 1'b1;
                    state_nxt   = MOVE;
                end
            end
            MOVE: begin
                do_line = 1'b1;
                if (line_cnt == 2'd3) state_nxt = EVAL;
            end
            EVAL: begin
                do_eval   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        line_idx = '0;
        line_in  = '0;
        for (int j = 0; j < 4; j++) begin
            line_idx[j] = line_cell(dir_q, line_cnt, 2'(j));
            line_in[j]  = grid[line_idx[j]];
        end
    end

    line_merge #(
        .MAX_EXP (MAX_EXP)
    ) u_line_merge (
        .line_in      (line_in),
        .line_out     (line_out),
        .line_changed (line_changed),
        .line_score   (line_score)
    );

    always_comb begin
        score_sum = SUM_W'(score_delta) + SUM_W'(line_score);
        score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    always_comb begin
        movable_scan = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (grid[i] == '0) movable_scan = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (can_merge(grid[r*4+c], grid[r*4+c+1])) movable_scan = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (can_merge(grid[r*4+c], grid[(r+1)*4+c])) movable_scan = 1'b1;
            end
        end
    end

    always_comb begin
        total_current_state = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            total_current_state[4*i +: 4] = grid[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++) grid[i] <= '0;
            dir_q       <= '0;
            line_cnt    <= '0;
            armed       <= 1'b1;
            preset_pend <= 1'b0;
            board_done  <= '0;
            changed     <= 1'b0;
            score_delta <= '0;
            busy        <= 1'b0;
            movable     <= 1'b1;
        end else begin
            preset_pend <= write_preset;
            if (write_preset) grid[preset_location] <= preset_value;

            if (accept_move) begin
                dir_q       <= direction;
                armed       <= 1'b0;
                line_cnt    <= '0;
                changed     <= 1'b0;
                score_delta <= '0;
                busy        <= 1'b1;
            end else if (direction == '0) begin
                armed <= 1'b1;
            end

            if (do_line) begin
                for (int j = 0; j < 4; j++) grid[line_idx[j]] <= line_out[j];
                changed     <= changed | line_changed;
                score_delta <= score_sat;
                line_cnt    <= line_cnt + 2'd1;
            end

            if (do_eval) begin
                board_done <= dir_q;
                busy       <= 1'b0;
            end else if (direction == '0) begin
                board_done <= '0;
            end

            if (do_eval || preset_pend) movable <= movable_scan;
        end
    end

endmodule

// File: tb/tb_board_engine.sv
// Directed self-checking bench for board_engine.
module tb_board_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  direction;
    logic        preset_ext;
    logic [3:0]  preset_location;
    logic [3:0]  preset_value;
    logic [63:0] total_current_state;
    logic [3:0]  board_done;
    logic        movable;
    logic        changed;
    logic [15:0] score_delta;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    board_engine #(.MAX_EXP(15), .SCORE_W(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .direction           (direction),
        .preset_ext          (preset_ext),
        .preset_location     (preset_location),
        .preset_value        (preset_value),
        .total_current_state (total_current_state),
        .board_done          (board_done),
        .movable             (movable),
        .changed             (changed),
        .score_delta         (score_delta),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1; direction = '0; preset_ext = 1'b0;
        preset_location = '0; preset_value = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic preset(input logic [3:0] loc, input logic [3:0] val);
        preset_ext = 1'b1; preset_location = loc; preset_value = val;
        @(negedge clk);
        preset_ext = 1'b0;
    endtask

    task automatic run_move(input logic [3:0] d, output int lat);
        direction = d;
        lat = 0;
        while (lat < 20 && board_done == 4'b0) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_dir();
        direction = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (total_current_state !== 64'h0) begin n_err++; $display("FAIL reset_grid got=%h exp=0", total_current_state); end
        n_cmp++; if (movable !== 1'b1) begin n_err++; $display("FAIL reset_movable got=%b exp=1", movable); end
        n_cmp++; if (board_done !== 4'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0000", board_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL reset_changed got=%b exp=0", changed); end
        n_cmp++; if (score_delta !== 16'h0) begin n_err++; $display("FAIL reset_score got=%0d exp=0", score_delta); end
        preset(4'd0, 4'd1);
        preset(4'd5, 4'd1);
        @(negedge clk);
        n_cmp++; if (total_current_state !== 64'h0000_0000_0010_0001) begin n_err++; $display("FAIL preset_grid got=%h exp=0000000000100001", total_current_state); end
        n_cmp++; if (movable !== 1'b1) begin n_err++; $display("FAIL preset_movable got=%b exp=1", movable); end
        n_cmp++; if (board_done !== 4'b0) begin n_err++; $display("FAIL preset_done got=%b exp=0000", board_done); end
    endtask

    task automatic test_left_merge();
        int lat;
        logic quiet;
        apply_reset();
        for (int i = 0; i < 4; i++) preset(4'(i), 4'd1);
        run_move(4'b0001, lat);
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL left_latency got=%0d exp=6", lat); end
        n_cmp++; if (total_current_state !== 64'h22) begin n_err++; $display("FAIL left_grid got=%h exp=22", total_current_state); end
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL left_changed got=%b exp=1", changed); end
        n_cmp++; if (score_delta !== 16'd8) begin n_err++; $display("FAIL left_score got=%0d exp=8", score_delta); end
        n_cmp++; if (board_done !== 4'b0001) begin n_err++; $display("FAIL left_done got=%b exp=0001", board_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL left_busy got=%b exp=0", busy); end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || total_current_state != 64'h22 || board_done != 4'b0001) quiet = 1'b0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL held_dir_retrigger got=%b exp=1", quiet); end
        release_dir();
        n_cmp++; if (board_done !== 4'b0) begin n_err++; $display("FAIL done_clear got=%b exp=0000", board_done); end
    endtask

    task automatic test_right_merge();
        int lat;
        apply_reset();
        preset(4'd0, 4'd1);
        preset(4'd2, 4'd1);
        preset(4'd3, 4'd2);
        run_move(4'b0010, lat);
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL right_latency got=%0d exp=6", lat); end
        n_cmp++; if (total_current_state !== 64'h2200) begin n_err++; $display("FAIL right_grid got=%h exp=2200", total_current_state); end
        n_cmp++; if (score_delta !== 16'd4) begin n_err++; $display("FAIL right_score got=%0d exp=4", score_delta); end
        n_cmp++; if (board_done !== 4'b0010) begin n_err++; $display("FAIL right_done got=%b exp=0010", board_done); end
        release_dir();
    endtask

    task automatic test_back_to_back();
        int lat;
        apply_reset();
        preset(4'd0, 4'd3);
        preset(4'd4, 4'd3);
        preset(4'd8, 4'd3);
        run_move(4'b1000, lat);
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL down_latency got=%0d exp=6", lat); end
        n_cmp++; if (total_current_state !== 64'h0004_0003_0000_0000) begin n_err++; $display("FAIL down_grid got=%h exp=0004000300000000", total_current_state); end
        n_cmp++; if (score_delta !== 16'd16) begin n_err++; $display("FAIL down_score got=%0d exp=16", score_delta); end
        n_cmp++; if (changed !== 1'b1) begin n_err++; $display("FAIL down_changed got=%b exp=1", changed); end
        release_dir();
        n_cmp++; if (board_done !== 4'b0) begin n_err++; $display("FAIL down_done_clear got=%b exp=0000", board_done); end
        run_move(4'b1000, lat);
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL down2_latency got=%0d exp=6", lat); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL down2_changed got=%b exp=0", changed); end
        n_cmp++; if (score_delta !== 16'd0) begin n_err++; $display("FAIL down2_score got=%0d exp=0", score_delta); end
        n_cmp++; if (board_done !== 4'b1000) begin n_err++; $display("FAIL down2_done got=%b exp=1000", board_done); end
        n_cmp++; if (total_current_state !== 64'h0004_0003_0000_0000) begin n_err++; $display("FAIL down2_grid got=%h exp=0004000300000000", total_current_state); end
        release_dir();
    endtask

    task automatic test_no_change();
        int lat;
        apply_reset();
        preset(4'd0, 4'd2);
        preset(4'd1, 4'd1);
        run_move(4'b0001, lat);
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL packed_changed got=%b exp=0", changed); end
        n_cmp++; if (score_delta !== 16'd0) begin n_err++; $display("FAIL packed_score got=%0d exp=0", score_delta); end
        n_cmp++; if (board_done !== 4'b0001) begin n_err++; $display("FAIL packed_done got=%b exp=0001", board_done); end
        n_cmp++; if (total_current_state !== 64'h12) begin n_err++; $display("FAIL packed_grid got=%h exp=12", total_current_state); end
        release_dir();
    endtask

    task automatic test_max_exp();
        int lat;
        apply_reset();
        preset(4'd0, 4'd15);
        preset(4'd1, 4'd15);
        run_move(4'b0001, lat);
        n_cmp++; if (total_current_state !== 64'hFF) begin n_err++; $display("FAIL maxexp_grid got=%h exp=ff", total_current_state); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL maxexp_changed got=%b exp=0", changed); end
        n_cmp++; if (score_delta !== 16'd0) begin n_err++; $display("FAIL maxexp_score got=%0d exp=0", score_delta); end
        release_dir();
    endtask

    task automatic test_score_saturate();
        int lat;
        apply_reset();
        preset(4'd0, 4'd14);
        preset(4'd1, 4'd14);
        preset(4'd4, 4'd14);
        preset(4'd5, 4'd14);
        run_move(4'b0001, lat);
        n_cmp++; if (total_current_state !== 64'h000F_000F) begin n_err++; $display("FAIL sat_grid got=%h exp=000f000f", total_current_state); end
        n_cmp++; if (score_delta !== 16'hFFFF) begin n_err++; $display("FAIL sat_score got=%0d exp=65535", score_delta); end
        release_dir();
    endtask

    task automatic test_checkerboard();
        int lat;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            preset(4'(i), ((i / 4 + i % 4) % 2 == 0) ? 4'd1 : 4'd2);
            if (i == 14) begin
                @(negedge clk);
                n_cmp++; if (movable !== 1'b1) begin n_err++; $display("FAIL checker_one_empty got=%b exp=1", movable); end
            end
        end
        @(negedge clk);
        n_cmp++; if (movable !== 1'b0) begin n_err++; $display("FAIL checker_preset_movable got=%b exp=0", movable); end
        n_cmp++; if (total_current_state !== 64'h1212_2121_1212_2121) begin n_err++; $display("FAIL checker_grid got=%h exp=1212212112122121", total_current_state); end
        run_move(4'b0100, lat);
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL checker_latency got=%0d exp=6", lat); end
        n_cmp++; if (movable !== 1'b0) begin n_err++; $display("FAIL checker_eval_movable got=%b exp=0", movable); end
        n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL checker_changed got=%b exp=0", changed); end
        release_dir();
    endtask

    task automatic test_preset_occupied();
        apply_reset();
        preset(4'd6, 4'd3);
        preset(4'd6, 4'd5);
        @(negedge clk);
        n_cmp++; if (total_current_state !== 64'h0300_0000) begin n_err++; $display("FAIL occupied_grid got=%h exp=03000000", total_current_state); end
    endtask

    task automatic test_reset_mid_move();
        apply_reset();
        for (int i = 0; i < 4; i++) preset(4'(i), 4'd1);
        direction = 4'b0001;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        direction = '0;
        #1;
        n_cmp++; if (total_current_state !== 64'h0) begin n_err++; $display("FAIL midrst_grid got=%h exp=0", total_current_state); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (movable !== 1'b1) begin n_err++; $display("FAIL midrst_movable got=%b exp=1", movable); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multi_bit_dir();
        logic idle_ok;
        apply_reset();
        preset(4'd1, 4'd1);
        direction = 4'b0011;
        idle_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || board_done != 4'b0) idle_ok = 1'b0;
        end
        n_cmp++; if (idle_ok !== 1'b1) begin n_err++; $display("FAIL multibit_ignored got=%b exp=1", idle_ok); end
        n_cmp++; if (total_current_state !== 64'h10) begin n_err++; $display("FAIL multibit_grid got=%h exp=10", total_current_state); end
        release_dir();
    endtask

    task automatic test_preset_while_busy();
        int lat;
        apply_reset();
        preset(4'd0, 4'd1);
        preset(4'd1, 4'd1);
        direction = 4'b0001;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_during_move got=%b exp=1", busy); end
        preset(4'd5, 4'd7);
        lat = 0;
        while (lat < 20 && board_done == 4'b0) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (board_done !== 4'b0001) begin n_err++; $display("FAIL busy_preset_done got=%b exp=0001", board_done); end
        n_cmp++; if (total_current_state !== 64'h2) begin n_err++; $display("FAIL busy_preset_dropped got=%h exp=2", total_current_state); end
        n_cmp++; if (score_delta !== 16'd4) begin n_err++; $display("FAIL busy_preset_score got=%0d exp=4", score_delta); end
        release_dir();
    endtask

    initial begin
        rst = 1'b1; direction = '0; preset_ext = 1'b0;
        preset_location = '0; preset_value = '0;
        test_reset();
        test_left_merge();
        test_right_merge();
        test_back_to_back();
        test_no_change();
        test_max_exp();
        test_score_saturate();
        test_checkerboard();
        test_preset_occupied();
        test_reset_mid_move();
        test_multi_bit_dir();
        test_preset_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
